// File: rtl/sdram_frame_arbiter_pkg.sv
// Shared types and defaults for the SDRAM frame-buffer arbiter.
// The arbiter FSM, grant sides and frame geometry live here.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } grant_side_e;

  localparam int DEF_BURST_LEN   = 256;
  localparam int DEF_FRAME_WORDS = 307200;

endpackage

// File: rtl/sdram_addr_gen.sv
// Frame-buffer burst address generator for one side (camera write or VGA read).
// A frame-start pulse is remembered and only applied while the arbiter is idle.
module sdram_addr_gen #(
  parameter int ADDR_W      = 24,
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200,
  parameter int FRAME_BASE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idle_i,
  input  logic              start_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(FRAME_BASE + FRAME_WORDS);

  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic              pend_q, pend_d;

  // Reload while idle, otherwise advance on burst completion and latch frame starts.
  always_comb begin
    addr_inc = addr_q + STEP;
    addr_d   = addr_q;
    pend_d   = pend_q;
    addr_o   = addr_q;
    if (idle_i) begin
      pend_d = 1'b0;
      if (pend_q || start_i) begin
        addr_d = BASE;
        addr_o = BASE;
      end else begin
        addr_d = addr_q;
        addr_o = addr_q;
      end
    end else begin
      // A pulse landing with the final increment still reloads at the next idle.
      if (start_i) begin
        pend_d = 1'b1;
      end else begin
        pend_d = pend_q;
      end
      if (adv_i) begin
        addr_d = (addr_inc == LIMIT) ? BASE : addr_inc;
      end else begin
        addr_d = addr_q;
      end
    end
  end

  // Address and pending-reload state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= BASE;
      pend_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Arbitrates the single SDRAM burst controller between the camera write FIFO
// and the VGA read FIFO, one burst command at a time.
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int LVL_W       = 11,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int FRAME_BASE  = 0,
  parameter int RD_LOW_TH   = 256,
  parameter int WR_HIGH_TH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [LVL_W-1:0]  wr_level,
  input  logic [LVL_W-1:0]  rd_level,
  input  logic              wr_frame_start,
  input  logic              rd_frame_start,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              burst_done,
  output logic              wr_grant,
  output logic              rd_grant
);

  localparam logic [LVL_W-1:0]  BURST_LVL   = LVL_W'(BURST_LEN);
  // Read side requests when the half-depth FIFO has room for a whole burst.
  localparam logic [LVL_W-1:0]  RD_MAX_LVL  = LVL_W'((2 ** (LVL_W - 1)) - BURST_LEN);
  localparam logic [LVL_W-1:0]  RD_LOW_LVL  = LVL_W'(RD_LOW_TH);
  localparam logic [LVL_W-1:0]  WR_HIGH_LVL = LVL_W'(WR_HIGH_TH);
  localparam logic [ADDR_W-1:0] BASE        = ADDR_W'(FRAME_BASE);

  arb_state_e        state_q, state_d;
  grant_side_e       last_grant_q, last_grant_d, pick_s;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              wr_grant_q, wr_grant_d;
  logic              rd_grant_q, rd_grant_d;
  logic              wr_req_s, rd_req_s, wr_urg_s, rd_urg_s;
  logic              idle_s, wr_adv_s, rd_adv_s;
  logic [ADDR_W-1:0] wr_addr_s, rd_addr_s;

  assign idle_s   = (state_q == IDLE);
  assign wr_adv_s = (state_q == WAIT_DONE) && burst_done && wr_grant_q;
  assign rd_adv_s = (state_q == WAIT_DONE) && burst_done && rd_grant_q;

  sdram_addr_gen #(
    .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS), .FRAME_BASE(FRAME_BASE)
  ) u_wr_addr (
    .clk(clk), .rst(rst), .idle_i(idle_s), .start_i(wr_frame_start),
    .adv_i(wr_adv_s), .addr_o(wr_addr_s)
  );

  sdram_addr_gen #(
    .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS), .FRAME_BASE(FRAME_BASE)
  ) u_rd_addr (
    .clk(clk), .rst(rst), .idle_i(idle_s), .start_i(rd_frame_start),
    .adv_i(rd_adv_s), .addr_o(rd_addr_s)
  );

  // Request qualification and priority: read urgent, write urgent, then round-robin.
  always_comb begin
    wr_req_s = (wr_level >= BURST_LVL);
    rd_req_s = (rd_level <= RD_MAX_LVL);
    rd_urg_s = rd_req_s && (rd_level < RD_LOW_LVL);
    wr_urg_s = wr_req_s && (wr_level >= WR_HIGH_LVL);
    pick_s   = WR;
    if (rd_urg_s) begin
      pick_s = RD;
    end else if (wr_urg_s) begin
      pick_s = WR;
    end else if (wr_req_s && rd_req_s) begin
      pick_s = (last_grant_q == WR) ? RD : WR;
    end else if (rd_req_s) begin
      pick_s = RD;
    end else begin
      pick_s = WR;
    end
  end

  // Arbiter FSM next state and registered command outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    wr_grant_d   = wr_grant_q;
    rd_grant_d   = rd_grant_q;
    case (state_q)
      IDLE: begin
        if (init_done && (wr_req_s || rd_req_s)) begin
          state_d      = ISSUE;
          last_grant_d = pick_s;
          cmd_valid_d  = 1'b1;
          cmd_write_d  = (pick_s == WR);
          cmd_addr_d   = (pick_s == WR) ? wr_addr_s : rd_addr_s;
          wr_grant_d   = (pick_s == WR);
          rd_grant_d   = (pick_s == RD);
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_d     = WAIT_DONE;
          cmd_valid_d = 1'b0;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_DONE: begin
        if (burst_done) begin
          state_d    = IDLE;
          wr_grant_d = 1'b0;
          rd_grant_d = 1'b0;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_valid_d = 1'b0;
        wr_grant_d  = 1'b0;
        rd_grant_d  = 1'b0;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= WR;
      cmd_valid_q  <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= BASE;
      wr_grant_q   <= 1'b0;
      rd_grant_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      wr_grant_q   <= wr_grant_d;
      rd_grant_q   <= rd_grant_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_write = cmd_write_q;
  assign cmd_addr  = cmd_addr_q;
  assign wr_grant  = wr_grant_q;
  assign rd_grant  = rd_grant_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Scoreboard bench for sdram_frame_arbiter: expected burst commands are queued
// as each scenario is set up and popped as the arbiter issues them.
module tb_sdram_frame_arbiter;

  typedef struct packed {
    logic        w;
    logic [23:0] a;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done = 1'b0;
  logic [10:0] wr_level = 11'd0;
  logic [10:0] rd_level = 11'd0;
  logic        wr_frame_start = 1'b0;
  logic        rd_frame_start = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        cmd_write;
  logic [23:0] cmd_addr;
  logic        burst_done = 1'b0;
  logic        wr_grant;
  logic        rd_grant;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  sdram_frame_arbiter dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr_level(wr_level), .rd_level(rd_level),
    .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .burst_done(burst_done),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; cmd_ready = 1'b0; burst_done = 1'b0;
    wr_frame_start = 1'b0; rd_frame_start = 1'b0; init_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Acts as the SDRAM controller for one burst; returns what was observed.
  task automatic serve_burst(input int stall, input int done_wait, input int pulse_mode,
                             output bit ok, output int lat, output logic w,
                             output logic [23:0] a, output logic wg, output logic rg);
    ok = 1'b0; lat = 0; w = 1'b0; a = 24'd0; wg = 1'b0; rg = 1'b0;
    while (cmd_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (cmd_valid === 1'b1) begin
      w = cmd_write; a = cmd_addr; wg = wr_grant; rg = rd_grant;
      repeat (stall) begin
        @(posedge clk);
        #1;
      end
      cmd_ready = 1'b1;
      @(posedge clk);
      #1;
      cmd_ready = 1'b0;
      for (int i = 0; i < done_wait; i++) begin
        wr_frame_start = (pulse_mode == 1 && i == 0);
        @(posedge clk);
        #1;
        wr_frame_start = 1'b0;
      end
      burst_done = 1'b1;
      wr_frame_start = (pulse_mode == 2);
      @(posedge clk);
      #1;
      burst_done = 1'b0;
      wr_frame_start = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
    n_checks++; if (cmd_write !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_write: got %b expected 0", cmd_write); end
    n_checks++; if (cmd_addr !== 24'd0) begin n_fail++; $display("FAIL reset_cmd_addr: got %0d expected 0", cmd_addr); end
    n_checks++; if (wr_grant !== 1'b0) begin n_fail++; $display("FAIL reset_wr_grant: got %b expected 0", wr_grant); end
    n_checks++; if (rd_grant !== 1'b0) begin n_fail++; $display("FAIL reset_rd_grant: got %b expected 0", rd_grant); end
  endtask

  task automatic test_init_gate();
    bit ok; int lat; logic w, wg, rg; logic [23:0] a; exp_t e;
    do_reset();
    wr_level = 11'd600; rd_level = 11'd1024;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL init_gate_idle: got cmd_valid=%b expected 0", cmd_valid); end
    end
    init_done = 1'b1;
    sb.push_back('{w: 1'b1, a: 24'd0});
    serve_burst(0, 2, 0, ok, lat, w, a, wg, rg);
    e = sb.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL init_gate_timeout: got no cmd_valid expected cmd_valid=1"); end
    else begin
      n_checks++; if (lat < 1 || lat > 2) begin n_fail++; $display("FAIL init_gate_latency: got %0d expected 1..2", lat); end
      n_checks++; if (w !== e.w || a !== e.a) begin n_fail++; $display("FAIL init_gate_cmd: got w=%b a=%0d expected w=%b a=%0d", w, a, e.w, e.a); end
      n_checks++; if (wg !== 1'b1 || rg !== 1'b0) begin n_fail++; $display("FAIL init_gate_grant: got wg=%b rg=%b expected 1 0", wg, rg); end
    end
  endtask

  task automatic test_read_urgent();
    bit ok; int lat; logic w, wg, rg; logic [23:0] a; exp_t e;
    do_reset();
    init_done = 1'b1; wr_level = 11'd300; rd_level = 11'd100;
    sb.push_back('{w: 1'b0, a: 24'd0});
    serve_burst(0, 1, 0, ok, lat, w, a, wg, rg);
    e = sb.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL read_urgent_timeout: got no cmd_valid expected cmd_valid=1"); end
    else if (w !== e.w || a !== e.a || rg !== 1'b1 || wg !== 1'b0) begin
      n_fail++;
      $display("FAIL read_urgent_cmd: got w=%b a=%0d wg=%b rg=%b expected w=%b a=%0d wg=0 rg=1", w, a, wg, rg, e.w, e.a);
    end
  endtask

  task automatic test_round_robin();
    bit ok; int lat; logic w, wg, rg; logic [23:0] a; exp_t e;
    do_reset();
    init_done = 1'b1; wr_level = 11'd300; rd_level = 11'd600;
    sb.push_back('{w: 1'b0, a: 24'd0});
    sb.push_back('{w: 1'b1, a: 24'd0});
    sb.push_back('{w: 1'b0, a: 24'd256});
    for (int k = 0; k < 3; k++) begin
      serve_burst(0, 1, 0, ok, lat, w, a, wg, rg);
      e = sb.pop_front();
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL round_robin_timeout: burst %0d got none expected a command", k); end
      else begin
        if (w !== e.w || a !== e.a || wg !== e.w || rg !== !e.w) begin
          n_fail++;
          $display("FAIL round_robin_cmd: burst %0d got w=%b a=%0d wg=%b rg=%b expected w=%b a=%0d", k, w, a, wg, rg, e.w, e.a);
        end
        if (k > 0) begin
          n_checks++;
          if (lat !== 1) begin n_fail++; $display("FAIL back_to_back_gap: burst %0d got %0d edges after done cycle expected 1", k, lat); end
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok; int lat; logic w, wg, rg; logic [23:0] a; exp_t e;
    do_reset();
    init_done = 1'b1; wr_level = 11'd300; rd_level = 11'd1024;
    for (int k = 0; k < 1200; k++) sb.push_back('{w: 1'b1, a: 24'(k * 256)});
    sb.push_back('{w: 1'b1, a: 24'd0});
    for (int k = 0; k < 1201; k++) begin
      serve_burst(0, 0, 0, ok, lat, w, a, wg, rg);
      e = sb.pop_front();
      n_checks++;
      if (!ok || w !== e.w || a !== e.a) begin
        n_fail++;
        $display("FAIL wrap_addr: burst %0d got ok=%b w=%b a=%0d expected w=%b a=%0d", k, ok, w, a, e.w, e.a);
        break;
      end
    end
  endtask

  task automatic test_frame_start();
    bit ok; int lat; logic w, wg, rg; logic [23:0] a; exp_t e;
    int pulse[8] = '{0, 0, 0, 0, 1, 0, 2, 0};
    do_reset();
    init_done = 1'b1; wr_level = 11'd300; rd_level = 11'd1024;
    sb.push_back('{w: 1'b1, a: 24'd0});
    sb.push_back('{w: 1'b1, a: 24'd256});
    sb.push_back('{w: 1'b1, a: 24'd512});
    sb.push_back('{w: 1'b1, a: 24'd768});
    sb.push_back('{w: 1'b1, a: 24'd1024});
    sb.push_back('{w: 1'b1, a: 24'd0});
    sb.push_back('{w: 1'b1, a: 24'd256});
    sb.push_back('{w: 1'b1, a: 24'd0});
    for (int k = 0; k < 8; k++) begin
      serve_burst(0, 2, pulse[k], ok, lat, w, a, wg, rg);
      e = sb.pop_front();
      n_checks++;
      if (!ok || w !== e.w || a !== e.a) begin
        n_fail++;
        $display("FAIL frame_start_addr: burst %0d got ok=%b w=%b a=%0d expected w=%b a=%0d", k, ok, w, a, e.w, e.a);
      end
    end
  endtask

  task automatic test_stall_and_reset();
    int lat;
    do_reset();
    init_done = 1'b1; wr_level = 11'd300; rd_level = 11'd1024;
    lat = 0;
    while (cmd_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_write !== 1'b1 || cmd_addr !== 24'd0) begin
        n_fail++;
        $display("FAIL stall_stable: cycle %0d got v=%b w=%b a=%0d expected v=1 w=1 a=0", i, cmd_valid, cmd_write, cmd_addr);
      end
      @(posedge clk);
      #1;
    end
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_ready = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (cmd_valid !== 1'b0 || wr_grant !== 1'b1) begin
      n_fail++; $display("FAIL wait_done_state: got v=%b wg=%b expected v=0 wg=1", cmd_valid, wr_grant);
    end
    cmd_addr_check_setup: begin
      rst = 1'b1;
      #1;
    end
    n_checks++;
    if (cmd_valid !== 1'b0 || cmd_write !== 1'b0 || cmd_addr !== 24'd0 || wr_grant !== 1'b0 || rd_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_burst_reset: got v=%b w=%b a=%0d wg=%b rg=%b expected all 0", cmd_valid, cmd_write, cmd_addr, wr_grant, rd_grant);
    end
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_init_gate();
    test_read_urgent();
    test_round_robin();
    test_wrap();
    test_frame_start();
    test_stall_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
